// File: rtl/fifo_controller.sv
// Pointer and flag controller for a circular-buffer FIFO of depth 2**ADDR_WIDTH.
// Optional occupancy count output is enabled with `define FIFO_CTRL_COUNT_EN.
module fifo_controller #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  read_i,
  input  logic                  write_i,
  output logic                  empty_o,
  output logic                  full_o,
`ifdef FIFO_CTRL_COUNT_EN
  output logic [ADDR_WIDTH:0]   count_o,
`endif
  output logic [ADDR_WIDTH-1:0] write_address_o,
  output logic [ADDR_WIDTH-1:0] read_address_o
);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic                  r_full;
  logic                  r_empty;

  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic [ADDR_WIDTH-1:0] w_wr_next;
  logic [ADDR_WIDTH-1:0] w_rd_next;

  assign w_rd_ok   = read_i & ~r_empty;
  // A write while full is accepted only when a read frees the head slot in the same cycle.
  assign w_wr_ok   = write_i & (~r_full | w_rd_ok);
  assign w_wr_next = r_wr_ptr + 1'b1;
  assign w_rd_next = r_rd_ptr + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_ok) r_wr_ptr <= w_wr_next;
      if (w_rd_ok) r_rd_ptr <= w_rd_next;
      case ({w_wr_ok, w_rd_ok})
        2'b10: begin
          r_empty <= 1'b0;
          r_full  <= (w_wr_next == r_rd_ptr);
        end
        2'b01: begin
          r_full  <= 1'b0;
          r_empty <= (w_rd_next == r_wr_ptr);
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_CTRL_COUNT_EN
  logic [ADDR_WIDTH:0] r_count;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_count <= '0;
    end else begin
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  assign count_o = r_count;
`endif

  assign empty_o         = r_empty;
  assign full_o          = r_full;
  assign write_address_o = r_wr_ptr;
  assign read_address_o  = r_rd_ptr;

endmodule

// File: tb/tb_fifo_controller.sv
// Directed self-checking bench for fifo_controller (ADDR_WIDTH=4).
// Expected values are hand-derived from the pointer/flag rules.
module tb_fifo_controller;

  localparam int AW = 4;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          read_i = 1'b0;
  logic          write_i = 1'b0;
  logic          empty_o;
  logic          full_o;
  logic [AW-1:0] write_address_o;
  logic [AW-1:0] read_address_o;
`ifdef FIFO_CTRL_COUNT_EN
  logic [AW:0]   count_o;
`endif

  int checks = 0;
  int errors = 0;

  fifo_controller #(.ADDR_WIDTH(AW)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .read_i          (read_i),
    .write_i         (write_i),
    .empty_o         (empty_o),
    .full_o          (full_o),
`ifdef FIFO_CTRL_COUNT_EN
    .count_o         (count_o),
`endif
    .write_address_o (write_address_o),
    .read_address_o  (read_address_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample #1 after the edge.
  task automatic step(input logic rst, input logic rd, input logic wr);
    reset_i = rst;
    read_i  = rd;
    write_i = wr;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_state(input string tag, input int wa, input int ra,
                             input logic e, input logic f, input int cnt);
    check({tag, ".wa"},    32'(write_address_o), 32'(wa));
    check({tag, ".ra"},    32'(read_address_o),  32'(ra));
    check({tag, ".empty"}, 32'(empty_o),         32'(e));
    check({tag, ".full"},  32'(full_o),          32'(f));
`ifdef FIFO_CTRL_COUNT_EN
    check({tag, ".count"}, 32'(count_o),         32'(cnt));
`endif
    if (cnt < 0) check({tag, ".neg"}, 32'(cnt), 32'd0);
  endtask

  initial begin
    // Reset held two cycles, then two idle cycles.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_state("reset", 0, 0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0);
      check_state($sformatf("idle%0d", i), 0, 0, 1'b1, 1'b0, 0);
    end

    // Fill: 16 accepted writes, 17th ignored.
    for (int i = 1; i <= 17; i++) begin
      step(1'b0, 1'b0, 1'b1);
      check_state($sformatf("fill%0d", i), (i < 16) ? i : 0, 0, 1'b0,
                  (i >= 16), (i < 16) ? i : 16);
    end

    // Drain: 16 accepted reads, 17th ignored.
    for (int i = 1; i <= 17; i++) begin
      step(1'b0, 1'b1, 1'b0);
      check_state($sformatf("drain%0d", i), 0, (i < 16) ? i : 0,
                  (i >= 16), 1'b0, (i < 16) ? 16 - i : 0);
    end

    // Simultaneous read+write starting empty.
    for (int i = 1; i <= 17; i++) begin
      step(1'b0, 1'b1, 1'b1);
      check_state($sformatf("simul_empty%0d", i), i % 16, (i - 1) % 16,
                  1'b0, 1'b0, 1);
    end

    // Simultaneous read+write when full.
    step(1'b1, 1'b0, 1'b0);
    check_state("reset2", 0, 0, 1'b1, 1'b0, 0);
    for (int i = 1; i <= 16; i++) step(1'b0, 1'b0, 1'b1);
    check_state("refill", 0, 0, 1'b0, 1'b1, 16);
    step(1'b0, 1'b1, 1'b1);
    check_state("simul_full", 1, 1, 1'b0, 1'b1, 16);

    // Mid-operation reset overrides a concurrent write.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b0, 1'b1);
    check_state("pre_reset", 5, 0, 1'b0, 1'b0, 5);
    step(1'b1, 1'b0, 1'b1);
    check_state("mid_reset", 0, 0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0);
    check_state("post_reset", 0, 0, 1'b1, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
